// File: rtl/div_clk_ratio_detector_pkg.sv
// Shared definitions for the divided-clock ratio detector:
// FSM state encoding, state width and match-counter width.
package div_clk_det_pkg;

   localparam int STATE_W    = 2;
   localparam int LOCK_CNT_W = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_MEAS   = 2'd2,
      ST_LOCKED = 2'd3
   } det_state_e;

   // True in the states where periods are being measured and timeouts apply
   function automatic logic is_measuring(input det_state_e st);
      return (st == ST_MEAS) || (st == ST_LOCKED);
   endfunction

endpackage

// File: rtl/div_clk_ratio_detector_if.sv
// Signal bundle between the detector and its environment.
// master: the side that enables the detector and supplies the divided clock.
// slave : the detector itself.
// Optional DIV_DET_DUTY_EN adds the high-time measurement o_high_cnt.
interface div_clk_ratio_detector_if #(
   parameter int RATIO_WIDTH = 8
);
   logic                   i_en;
   logic                   i_div_clk;
   logic [RATIO_WIDTH-1:0] o_ratio;
   logic                   o_valid;
   logic                   o_locked;
   logic                   o_unlock_err;
   logic                   o_timeout;
`ifdef DIV_DET_DUTY_EN
   logic [RATIO_WIDTH-1:0] o_high_cnt;

   modport master (
      output i_en, i_div_clk,
      input  o_ratio, o_valid, o_locked, o_unlock_err, o_timeout, o_high_cnt
   );

   modport slave (
      input  i_en, i_div_clk,
      output o_ratio, o_valid, o_locked, o_unlock_err, o_timeout, o_high_cnt
   );
`else
   modport master (
      output i_en, i_div_clk,
      input  o_ratio, o_valid, o_locked, o_unlock_err, o_timeout
   );

   modport slave (
      input  i_en, i_div_clk,
      output o_ratio, o_valid, o_locked, o_unlock_err, o_timeout
   );
`endif
endinterface

// File: rtl/div_clk_ratio_detector_edge_det.sv
// Edge detector for a signal already synchronous to i_ref_clk.
// Keeps one registered copy of the input and flags rising/falling edges
// combinationally in the cycle the new level is first seen.
module div_clk_edge_det (
   input  logic i_ref_clk,
   input  logic i_rst_n,
   input  logic i_din,
   output logic o_rise,
   output logic o_fall
);

   logic din_q;
   logic din_d;

   // Next value of the history register is simply the current input level
   always_comb begin
      din_d = i_din;
   end

   // History register, cleared to 0 so a high input right after reset reads as a rise
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         din_q <= 1'b0;
      end else begin
         din_q <= din_d;
      end
   end

   assign o_rise = i_din & ~din_q;
   assign o_fall = ~i_din & din_q;

endmodule

// File: rtl/div_clk_ratio_detector.sv
// Divided-clock ratio detector.
// Measures the period of i_div_clk in i_ref_clk cycles, reports every
// measurement, declares lock after LOCK_COUNT equal periods, and flags a
// period change while locked (o_unlock_err) or a stalled clock (o_timeout).
// LOCK_COUNT must lie in 1..15 (4-bit match counter).
// Build option: define DIV_DET_DUTY_EN to add o_high_cnt, the number of
// cycles i_div_clk was high during the last measured period.
module div_clk_ratio_detector
   import div_clk_det_pkg::*;
#(
   parameter int RATIO_WIDTH = 8,
   parameter int LOCK_COUNT  = 4
) (
   input  logic                     i_ref_clk,
   input  logic                     i_rst_n,
   div_clk_ratio_detector_if.slave  bus
);

   // cnt is one bit wider than the ratio so it can saturate at 2^RATIO_WIDTH
   localparam logic [RATIO_WIDTH:0]    CNT_ONE   = {{RATIO_WIDTH{1'b0}}, 1'b1};
   localparam logic [RATIO_WIDTH:0]    CNT_SAT   = {1'b1, {RATIO_WIDTH{1'b0}}};
   localparam logic [RATIO_WIDTH:0]    CNT_TO    = {1'b0, {RATIO_WIDTH{1'b1}}};
   localparam logic [LOCK_CNT_W-1:0]   MATCH_ONE = {{(LOCK_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [LOCK_CNT_W-1:0]   MATCH_MAX = {LOCK_CNT_W{1'b1}};
   localparam logic [LOCK_CNT_W-1:0]   LOCK_TGT  = LOCK_CNT_W'(LOCK_COUNT);

   det_state_e               state_q, state_d;
   logic [RATIO_WIDTH:0]     cnt_q, cnt_d;
   logic [RATIO_WIDTH:0]     prev_q, prev_d;
   logic [LOCK_CNT_W-1:0]    match_q, match_d;
   logic [RATIO_WIDTH-1:0]   ratio_q, ratio_d;
   logic                     valid_q, valid_d;
   logic                     locked_q, locked_d;
   logic                     unlock_q, unlock_d;
   logic                     timeout_q, timeout_d;

   logic                     div_rise;
   logic                     div_fall;
   logic [RATIO_WIDTH:0]     cnt_inc;
   logic [LOCK_CNT_W-1:0]    match_inc;
   logic [LOCK_CNT_W-1:0]    match_new;
   logic                     same_period;

   div_clk_edge_det u_edge (
      .i_ref_clk (i_ref_clk),
      .i_rst_n   (i_rst_n),
      .i_din     (bus.i_div_clk),
      .o_rise    (div_rise),
      .o_fall    (div_fall)
   );

   assign cnt_inc     = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + CNT_ONE;
   assign match_inc   = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + MATCH_ONE;
   // prev is cleared on arming, and cnt is never 0 at a rise, so the first
   // measurement always starts a fresh run of one
   assign same_period = (cnt_q == prev_q);
   assign match_new   = same_period ? match_inc : MATCH_ONE;

   // Next-state, period counting, lock tracking and output pulse generation
   always_comb begin
      state_d   = state_q;
      cnt_d     = div_rise ? CNT_ONE : cnt_inc;
      prev_d    = prev_q;
      match_d   = match_q;
      ratio_d   = ratio_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      unlock_d  = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.i_en) begin
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            // The first rise only starts the clock on a period; nothing is reported
            if (div_rise) begin
               prev_d  = '0;
               match_d = '0;
               state_d = ST_MEAS;
            end
         end
         ST_MEAS, ST_LOCKED: begin
            if (div_rise) begin
               valid_d = 1'b1;
               ratio_d = cnt_q[RATIO_WIDTH-1:0];
               prev_d  = cnt_q;
               if (state_q == ST_LOCKED) begin
                  if (!same_period) begin
                     locked_d = 1'b0;
                     unlock_d = 1'b1;
                     match_d  = MATCH_ONE;
                     state_d  = ST_MEAS;
                  end
               end else begin
                  match_d = match_new;
                  // >= so that LOCK_COUNT=1 can still re-lock after an unlock
                  if (match_new >= LOCK_TGT) begin
                     locked_d = 1'b1;
                     state_d  = ST_LOCKED;
                  end
               end
            end else if (cnt_q == CNT_TO) begin
               // cnt is about to reach 2^RATIO_WIDTH with no rise: clock has stalled
               timeout_d = 1'b1;
               locked_d  = 1'b0;
               match_d   = '0;
               state_d   = ST_ARM;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Disable overrides everything; the last ratio is kept for status reads
      if (!bus.i_en) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         match_d   = '0;
         locked_d  = 1'b0;
         valid_d   = 1'b0;
         unlock_d  = 1'b0;
         timeout_d = 1'b0;
      end
   end

   // State and status registers
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         prev_q    <= '0;
         match_q   <= '0;
         ratio_q   <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         unlock_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prev_q    <= prev_d;
         match_q   <= match_d;
         ratio_q   <= ratio_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         unlock_q  <= unlock_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.o_ratio      = ratio_q;
   assign bus.o_valid      = valid_q;
   assign bus.o_locked     = locked_q;
   assign bus.o_unlock_err = unlock_q;
   assign bus.o_timeout    = timeout_q;

`ifdef DIV_DET_DUTY_EN
   localparam logic [RATIO_WIDTH-1:0] HIGH_ONE = {{(RATIO_WIDTH-1){1'b0}}, 1'b1};

   logic [RATIO_WIDTH-1:0] high_cnt_q, high_cnt_d;
   logic [RATIO_WIDTH-1:0] high_cap_q, high_cap_d;
   logic [RATIO_WIDTH-1:0] high_out_q, high_out_d;
   logic                   meas_rise;

   // Same qualification as an o_ratio update, so o_high_cnt moves with o_valid
   assign meas_rise = bus.i_en && div_rise && is_measuring(state_q);

   // High-time counter restarts on rise, is snapshotted on fall, published on the next rise
   always_comb begin
      high_cnt_d = high_cnt_q;
      high_cap_d = high_cap_q;
      high_out_d = high_out_q;
      if (div_rise) begin
         high_cnt_d = HIGH_ONE;
      end else if (bus.i_div_clk && (high_cnt_q != {RATIO_WIDTH{1'b1}})) begin
         high_cnt_d = high_cnt_q + HIGH_ONE;
      end
      if (div_fall) begin
         high_cap_d = high_cnt_q;
      end
      if (meas_rise) begin
         high_out_d = high_cap_q;
      end
   end

   // High-time registers
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         high_cnt_q <= '0;
         high_cap_q <= '0;
         high_out_q <= '0;
      end else begin
         high_cnt_q <= high_cnt_d;
         high_cap_q <= high_cap_d;
         high_out_q <= high_out_d;
      end
   end

   assign bus.o_high_cnt = high_out_q;
`else
   // Falling edge only feeds the high-time option
   logic unused_fall;
   assign unused_fall = div_fall;
`endif

endmodule
